// File: rtl/axi_lite_bridge_if.sv
// AXI4-Lite bus bundle used between the bridge (master) and the interconnect (slave).
interface axi_lite_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  localparam int STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_bridge.sv
// Core data-memory port to single-beat AXI4-Lite master, one transaction outstanding.
// Optional sticky error flag err_o enabled by defining AXI_BRIDGE_ERR_EN.
module axi_lite_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                core_ren_i,
  input  logic [63:0]         core_raddr_i,
  input  logic                core_wen_i,
  input  logic [63:0]         core_waddr_i,
  input  logic [DATA_W-1:0]   core_wdata_i,
  input  logic [DATA_W/8-1:0] core_wmask_i,
  input  logic                core_flush_i,
  output logic [DATA_W-1:0]   core_rdata_o,
  output logic                core_rvalid_o,
  output logic                core_wdone_o,
  output logic                core_busy_o,
`ifdef AXI_BRIDGE_ERR_EN
  output logic                err_o,
`endif
  axi_lite_bridge_if.master   m
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA} state_t;

  state_t            state;
  logic              rd_pend;
  logic              drop;
  logic              drop_now;
  logic [ADDR_W-1:0] waddr_al;
  logic [ADDR_W-1:0] raddr_al;
  logic              unused_addr;

  // A flush arriving in the completing cycle still suppresses that completion.
  assign drop_now    = drop | core_flush_i;
  assign waddr_al    = {core_waddr_i[ADDR_W-1:3], 3'b000};
  assign raddr_al    = {core_raddr_i[ADDR_W-1:3], 3'b000};
  assign core_busy_o = (state != IDLE);
  assign unused_addr = ^{core_waddr_i[63:ADDR_W], core_waddr_i[2:0],
                         core_raddr_i[63:ADDR_W], core_raddr_i[2:0]};

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // read in this block sees the pre-edge value; later assignments override earlier ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      rd_pend       <= 1'b0;
      drop          <= 1'b0;
      core_rdata_o  <= '0;
      core_rvalid_o <= 1'b0;
      core_wdone_o  <= 1'b0;
      m.awaddr      <= '0;
      m.awvalid     <= 1'b0;
      m.wdata       <= '0;
      m.wstrb       <= '0;
      m.wvalid      <= 1'b0;
      m.bready      <= 1'b0;
      m.araddr      <= '0;
      m.arvalid     <= 1'b0;
      m.rready      <= 1'b0;
    end else begin
      core_rvalid_o <= 1'b0;
      core_wdone_o  <= 1'b0;
      // Issued transactions always run to completion; flush only hides the result.
      if (state != IDLE && core_flush_i) begin
        drop    <= 1'b1;
        rd_pend <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (!core_flush_i) begin
            if (core_wen_i) begin
              m.awaddr  <= waddr_al;
              m.wdata   <= core_wdata_i;
              m.wstrb   <= core_wmask_i;
              m.awvalid <= 1'b1;
              m.wvalid  <= 1'b1;
              rd_pend   <= core_ren_i;
              if (core_ren_i) m.araddr <= raddr_al;
              state     <= WR_REQ;
            end else if (core_ren_i) begin
              m.araddr  <= raddr_al;
              m.arvalid <= 1'b1;
              state     <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (m.awvalid && m.awready) m.awvalid <= 1'b0;
          if (m.wvalid && m.wready)   m.wvalid  <= 1'b0;
          if ((!m.awvalid || m.awready) && (!m.wvalid || m.wready)) begin
            m.bready <= 1'b1;
            state    <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m.bvalid) begin
            m.bready     <= 1'b0;
            core_wdone_o <= !drop_now;
            drop         <= 1'b0;
            rd_pend      <= 1'b0;
            if (rd_pend && !core_flush_i) begin
              m.arvalid <= 1'b1;
              state     <= RD_REQ;
            end else begin
              state <= IDLE;
            end
          end
        end
        RD_REQ: begin
          if (m.arready) begin
            m.arvalid <= 1'b0;
            m.rready  <= 1'b1;
            state     <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m.rvalid) begin
            m.rready <= 1'b0;
            if (!drop_now) begin
              core_rdata_o  <= m.rdata;
              core_rvalid_o <= 1'b1;
            end
            drop  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AXI_BRIDGE_ERR_EN
  // Sticky: any non-OKAY completion, dropped or not, latches until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_o <= 1'b0;
    end else begin
      if (state == WR_RESP && m.bvalid && m.bresp != 2'b00) err_o <= 1'b1;
      if (state == RD_DATA && m.rvalid && m.rresp != 2'b00) err_o <= 1'b1;
    end
  end
`else
  logic unused_resp;
  assign unused_resp = ^{m.bresp, m.rresp};
`endif

endmodule
